// File: rtl/cp0_unit_if.sv
// Controller-side bus for the CP0 unit: register access, exception strobes,
// interrupt lines and the EPC/interrupt/read-data returns.
interface cp0_unit_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned SELW = 5;
    localparam int unsigned IRQW = 6;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] din;
    logic [SELW-1:0] sel;
    logic            we;
    logic            exlset;
    logic            exlclr;
    logic [IRQW-1:0] hwint;
    logic            int_req;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] dout;

    modport master (
        output pc, din, sel, we, exlset, exlclr, hwint,
        input  int_req, epc, dout
    );

    modport slave (
        input  pc, din, sel, we, exlset, exlclr, hwint,
        output int_req, epc, dout
    );
endinterface

// File: rtl/cp0_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PrID with exception entry/return and interrupt request.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit (
    input  logic        clk,
    input  logic        rst,
    cp0_unit_if.slave   cp0
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned IRQW = 6;

    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_SR      = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;
    localparam logic [4:0] SEL_PRID    = 5'd15;

    localparam logic [XLEN-1:0] PRID_VAL = 32'h4D49_5053;

    logic [IRQW-1:0] r_im;
    logic [IRQW-1:0] r_ip;
    logic            r_exl;
    logic            r_ie;
    logic [XLEN-1:0] r_epc;

    logic            w_wr;
    logic            w_wr_sr;
    logic            w_wr_epc;
    logic            w_ti;
    logic [XLEN-1:0] w_sr;
    logic [XLEN-1:0] w_cause;
    logic            w_unused;

    // Exception entry blocks the register write carried in the same cycle
    assign w_wr     = cp0.we & ~cp0.exlset;
    assign w_wr_sr  = w_wr & (cp0.sel == SEL_SR);
    assign w_wr_epc = w_wr & (cp0.sel == SEL_EPC);
    assign w_unused = &{1'b0, cp0.pc[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_im  <= '0;
        end else begin
            if (cp0.exlset) begin
                r_exl <= 1'b1;
            end else if (cp0.exlclr) begin
                r_exl <= 1'b0;
            end else if (w_wr_sr) begin
                r_exl <= cp0.din[1];
            end
            if (w_wr_sr) begin
                r_im <= cp0.din[15:10];
                r_ie <= cp0.din[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= '0;
        end else if (cp0.exlset) begin
            r_epc <= {cp0.pc[XLEN-1:2], 2'b00};
        end else if (w_wr_epc) begin
            r_epc <= {cp0.din[XLEN-1:2], 2'b00};
        end
    end

    // Pending bits resample the lines every clock; the timer shares the top line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ip <= '0;
        end else begin
            r_ip <= {cp0.hwint[IRQW-1] | w_ti, cp0.hwint[IRQW-2:0]};
        end
    end

`ifdef CP0_TIMER_EN
    logic [XLEN-1:0] r_count;
    logic [XLEN-1:0] r_compare;
    logic            r_ti;
    logic            w_wr_count;
    logic            w_wr_compare;

    assign w_wr_count   = w_wr & (cp0.sel == SEL_COUNT);
    assign w_wr_compare = w_wr & (cp0.sel == SEL_COMPARE);
    assign w_ti         = r_ti;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= cp0.din;
            end else begin
                r_count <= r_count + XLEN'(1);
            end
            // A Compare write clears TI even when the match fires on the same edge
            if (w_wr_compare) begin
                r_compare <= cp0.din;
                r_ti      <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != '0)) begin
                r_ti      <= 1'b1;
            end
        end
    end
`else
    assign w_ti = 1'b0;
`endif

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {16'b0, r_ip, 10'b0};

    assign cp0.int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign cp0.epc     = r_epc;

    always_comb begin
        cp0.dout = '0;
        case (cp0.sel)
`ifdef CP0_TIMER_EN
            SEL_COUNT:   cp0.dout = r_count;
            SEL_COMPARE: cp0.dout = r_compare;
`endif
            SEL_SR:      cp0.dout = w_sr;
            SEL_CAUSE:   cp0.dout = w_cause;
            SEL_EPC:     cp0.dout = r_epc;
            SEL_PRID:    cp0.dout = PRID_VAL;
            default:     cp0.dout = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit; timer checks are compiled in with CP0_TIMER_EN.
module tb_cp0_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk (clk),
        .rst (rst),
        .cp0 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] s, input logic [31:0] exp);
        bus.sel = s;
        #1;
        check_eq(tag, bus.dout, exp);
    endtask

    task automatic wr(input logic [4:0] s, input logic [31:0] d);
        bus.sel = s;
        bus.din = d;
        bus.we  = 1'b1;
        tick();
        bus.we  = 1'b0;
        bus.din = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst        = 1'b0;
        bus.pc     = '0;
        bus.din    = '0;
        bus.sel    = '0;
        bus.we     = 1'b0;
        bus.exlset = 1'b0;
        bus.exlclr = 1'b0;
        bus.hwint  = '0;

        #12;
        rd("rst_prid", 5'd15, 32'h4D49_5053);
        rd("rst_sr", 5'd12, 32'h0);
        check_eq("rst_int_req", 32'(bus.int_req), 32'h0);
        check_eq("rst_epc", bus.epc, 32'h0);
        rst = 1'b1;
        tick();

        // Enable IM[10] and IE, raise hwint[0]
        wr(5'd12, 32'h0000_0401);
        bus.hwint = 6'b000001;
        check_eq("ip_latency", 32'(bus.int_req), 32'h0);
        tick();
        check_eq("irq_on", 32'(bus.int_req), 32'h1);
        rd("cause", 5'd13, 32'h0000_0400);
        rd("sr_wr", 5'd12, 32'h0000_0401);

        // Exception entry with a simultaneous (suppressed) SR write
        bus.pc     = 32'h0000_3010;
        bus.din    = 32'h0;
        bus.sel    = 5'd12;
        bus.we     = 1'b1;
        bus.exlset = 1'b1;
        tick();
        bus.we     = 1'b0;
        bus.exlset = 1'b0;
        check_eq("epc_entry", bus.epc, 32'h0000_3010);
        rd("sr_exl", 5'd12, 32'h0000_0403);
        rd("epc_rd", 5'd14, 32'h0000_3010);
        check_eq("irq_masked_exl", 32'(bus.int_req), 32'h0);

        // exlset beats exlclr; no EPC recapture without exlset
        bus.pc     = 32'h0000_5000;
        bus.exlset = 1'b1;
        bus.exlclr = 1'b1;
        bus.pc     = 32'h0000_3010;
        tick();
        bus.exlset = 1'b0;
        bus.exlclr = 1'b0;
        bus.pc     = 32'h0000_7777;
        rd("sr_set_wins", 5'd12, 32'h0000_0403);
        tick();
        check_eq("epc_hold", bus.epc, 32'h0000_3010);
        bus.exlclr = 1'b1;
        tick();
        bus.exlclr = 1'b0;
        rd("sr_eret", 5'd12, 32'h0000_0401);
        check_eq("irq_back", 32'(bus.int_req), 32'h1);

        // Unaligned pc capture, then SR write racing eret
        bus.pc     = 32'h0000_3013;
        bus.exlset = 1'b1;
        tick();
        bus.exlset = 1'b0;
        check_eq("epc_align_pc", bus.epc, 32'h0000_3010);
        bus.exlclr = 1'b1;
        wr(5'd12, 32'h0000_0403);
        bus.exlclr = 1'b0;
        rd("sr_wr_eret", 5'd12, 32'h0000_0401);

        // Read-only and unmapped registers ignore writes
        wr(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0400);
        wr(5'd15, 32'h0);
        rd("prid_ro", 5'd15, 32'h4D49_5053);
        wr(5'd20, 32'h1234_5678);
        rd("unmapped", 5'd20, 32'h0);
`ifndef CP0_TIMER_EN
        wr(5'd9, 32'h0000_0005);
        rd("count_absent", 5'd9, 32'h0);
        wr(5'd11, 32'h0000_0005);
        rd("compare_absent", 5'd11, 32'h0);
`endif

        wr(5'd14, 32'h0000_3007);
        rd("epc_wr_align", 5'd14, 32'h0000_3004);
        check_eq("irq_pre_rst", 32'(bus.int_req), 32'h1);

        // Async reset between edges
        bus.exlset = 1'b1;
        bus.pc     = 32'h0000_3010;
        tick();
        bus.exlset = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_epc", bus.epc, 32'h0);
        check_eq("async_irq", 32'(bus.int_req), 32'h0);
        rd("async_sr", 5'd12, 32'h0);
        rd("async_cause", 5'd13, 32'h0);
        bus.hwint = '0;
        #3;
        rst = 1'b1;
        tick();

`ifdef CP0_TIMER_EN
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'h0000_0005);
        wr(5'd9, 32'h0000_0000);
        rd("count_zero", 5'd9, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        rd("count_five", 5'd9, 32'h0000_0005);
        check_eq("ti_not_yet", 32'(bus.int_req), 32'h0);
        tick();
        check_eq("ti_ip_lag", 32'(bus.int_req), 32'h0);
        tick();
        check_eq("ti_irq", 32'(bus.int_req), 32'h1);
        rd("ti_cause", 5'd13, 32'h0000_8000);
        wr(5'd11, 32'h0000_0005);
        tick();
        check_eq("ti_cleared", 32'(bus.int_req), 32'h0);
        rd("compare_rd", 5'd11, 32'h0000_0005);
        wr(5'd9, 32'hFFFF_FFFF);
        rd("count_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd("count_wrap", 5'd9, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port pc, input, 32 bits: PC value captured into EPC on exception entry.
REQ-004 The block SHALL have port din, input, 32 bits: write data for register writes (GPR rt value).
REQ-005 The block SHALL have port sel, input, 5 bits: register number (rd field) for reads and writes.
REQ-006 The block SHALL have port we, input, 1 bit: register write enable (cp0_we).
REQ-007 The block SHALL have port exlset, input, 1 bit: exception entry strobe.
REQ-008 The block SHALL have port exlclr, input, 1 bit: exception return (eret) strobe.
REQ-009 The block SHALL have port hwint, input, 6 bits: level-sensitive hardware interrupt lines.
REQ-010 The block SHALL have port int_req, output, 1 bit: interrupt request to the controller.
REQ-011 The block SHALL have port epc, output, 32 bits: current EPC, feeding the eret NPC path.
REQ-012 The block SHALL have port dout, output, 32 bits: combinational read data for mfc0.

Function
REQ-013 Register map SHALL be: 12 SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; 13 Cause = {16'b0, IP[15:10], 10'b0}; 14 EPC; 15 PrID = 32'h4D49_5053. Any other sel SHALL read 0.
REQ-014 IP[15:10] SHALL be reloaded from hwint every clock, which is a 1-cycle sampling latency, and SHALL be read-only.
REQ-015 int_req SHALL equal |(IP & IM) & IE & ~EXL, computed combinationally from registered state.
REQ-016 On exlset at a clock edge, EXL SHALL become 1 and EPC SHALL become {pc[31:2], 2'b00}.
REQ-017 On exlclr at a clock edge, EXL SHALL become 0.
REQ-018 If exlset and exlclr are asserted in the same cycle, exlset SHALL win.
REQ-019 When we=1 and exlset=0, the register selected by sel SHALL be written; SR writes update IM, EXL and IE only, EPC writes are forced word-aligned, and writes to Cause, PrID or unmapped numbers SHALL be ignored.
REQ-020 When we and exlset are asserted together (controller interrupt state), the register write SHALL be suppressed and only the exception-entry effects of REQ-016 SHALL apply.
REQ-021 When we writes SR and exlclr is asserted in the same cycle, IM and IE SHALL take din and EXL SHALL be 0.
REQ-022 dout SHALL reflect the register contents before the current edge; a write is visible on the cycle after it.
REQ-023 While EXL=1, int_req SHALL stay 0 regardless of pending bits, and no further EPC capture SHALL occur unless exlset is asserted.

Reset
REQ-024 While rst=0, SR, IP, EPC, Count, Compare and TI SHALL be 0, so int_req=0, epc=0, and dout equals PrID when sel=15, otherwise 0.
REQ-025 Reset assertion mid-exception SHALL clear EXL and EPC immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro CP0_TIMER_EN defined, register 9 Count SHALL increment by 1 every clock and wrap from 32'hFFFF_FFFF to 0, and register 11 Compare SHALL be read/write.
REQ-027 With CP0_TIMER_EN defined, writes to Count SHALL take priority over the increment.
REQ-028 With CP0_TIMER_EN defined, a sticky TI bit SHALL be set when Count==Compare and Compare!=0.
REQ-029 With CP0_TIMER_EN defined, TI SHALL be cleared by any write to Compare; if the set and clear conditions coincide, the clear SHALL win.
REQ-030 With CP0_TIMER_EN defined, IP[15] SHALL equal hwint[5] | TI.
REQ-031 Without CP0_TIMER_EN, registers 9 and 11 SHALL read 0 and ignore writes, no TI bit SHALL exist, and IP[15] SHALL equal hwint[5].

Verification
REQ-032 The bench SHALL check: after reset, sel=15 gives dout=32'h4D49_5053; sel=12 gives 0; int_req=0.
REQ-033 The bench SHALL check: write SR=32'h0000_0401 (IM[10], IE); set hwint=6'b000001; one clock later int_req=1 and Cause=32'h0000_0400.
REQ-034 The bench SHALL check: with int_req=1, pc=32'h0000_3010, we=1, exlset=1, sel=12, din=0; after the clock, EPC=32'h0000_3010, SR=32'h0000_0403, int_req=0.
REQ-035 The bench SHALL check: continuing REQ-034, exlset=1 and exlclr=1 together keep EXL=1; exlclr alone then clears EXL, and int_req returns to 1 while hwint is still held.
REQ-036 The bench SHALL check: write EPC=32'h0000_3007; it reads back as 32'h0000_3004. Assert rst=0 between clock edges; EPC=0 and int_req=0 immediately.
REQ-037 The bench SHALL check, with CP0_TIMER_EN: Compare=5, IM[15]=1, IE=1; TI sets when Count reaches 5 and int_req=1; rewriting Compare clears TI. Preload Count=32'hFFFF_FFFF; the next cycle reads 0.
